// File: rtl/tc_sram_arbiter.sv
// tc_sram_arbiter
//
// Shares port 0 of a single-port tc_sram between NumReq requesters.
// It grants at most one access per cycle, using a round-robin priority pointer.
// Each granted access is tagged with its requester index. The tag travels
// through a pipeline matched to the SRAM read latency, so the response strobe
// returns to the requester that issued the access.
// When InitZero is set, the whole array is zero-filled after every reset.
// No requester is granted until the fill has finished.
//
// Ports:
//   clk_i, rst_i      clock and synchronous active-high reset
//   busy_o            high while the zero-fill is running
//   req_i/we_i/addr_i/wdata_i/be_i
//                     per-requester request and payload, held until granted
//   gnt_o             one-hot (or zero) grant, combinational from req_i
//   rvalid_o          per-requester response strobe, Latency cycles after grant
//   rdata_o           SRAM read data broadcast to every requester
//   sram_*_o          request signals driven into SRAM port 0
//   sram_rdata_i      read data coming back from SRAM port 0

module tc_sram_arbiter #(
  parameter int NumReq    = 4,
  parameter int NumWords  = 1024,
  parameter int DataWidth = 32,
  parameter int ByteWidth = 8,
  parameter int Latency   = 1,
  parameter bit InitZero  = 1'b0,
  parameter int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  output logic                                 busy_o,
  input  logic [NumReq-1:0]                    req_i,
  input  logic [NumReq-1:0]                    we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]       be_i,
  output logic [NumReq-1:0]                    gnt_o,
  output logic [NumReq-1:0]                    rvalid_o,
  output logic [DataWidth-1:0]                 rdata_o,
  output logic                                 sram_req_o,
  output logic                                 sram_we_o,
  output logic [AddrWidth-1:0]                 sram_addr_o,
  output logic [DataWidth-1:0]                 sram_wdata_o,
  output logic [BeWidth-1:0]                   sram_be_o,
  input  logic [DataWidth-1:0]                 sram_rdata_i
);

  localparam int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  // The fill counter is one bit wider than the address. A power-of-two depth
  // therefore never wraps the counter back to zero before the fill is done.
  localparam logic [AddrWidth:0] LastAddr = (AddrWidth + 1)'(NumWords - 1);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumReq - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e                            state_q;
  logic                              busy_q;
  logic [AddrWidth:0]                init_cnt_q;
  logic [IdxWidth-1:0]               rr_q;
  logic [Latency-1:0]                pipe_valid_q;
  logic [Latency-1:0][IdxWidth-1:0]  pipe_idx_q;

  logic                              grant_valid;
  logic [IdxWidth-1:0]               grant_idx;
  int                                cand;

  // Round-robin pick: the first requester at or after rr_q, wrapping around.
  // Grants are suppressed during reset and while the zero-fill owns the port.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NumReq; i++) begin
      cand = (int'(rr_q) + i) % NumReq;
      if (!grant_valid && req_i[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IdxWidth'(cand);
      end
    end
    if (rst_i || state_q != RUN) begin
      grant_valid = 1'b0;
      grant_idx   = '0;
    end
  end

  // Expand the selected index into the one-hot grant vector.
  always_comb begin
    gnt_o = '0;
    if (grant_valid) begin
      gnt_o[grant_idx] = 1'b1;
    end
  end

  // Drive the SRAM port. The zero-fill owns the port while in INIT.
  // Otherwise the granted requester's payload passes straight through.
  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (!rst_i && state_q == INIT) begin
      sram_req_o  = 1'b1;
      sram_we_o   = 1'b1;
      sram_addr_o = init_cnt_q[AddrWidth-1:0];
      sram_be_o   = '1;
    end else if (grant_valid) begin
      sram_req_o   = 1'b1;
      sram_we_o    = we_i[grant_idx];
      sram_addr_o  = addr_i[grant_idx];
      sram_wdata_o = wdata_i[grant_idx];
      sram_be_o    = be_i[grant_idx];
    end
  end

  // Fill/run state machine.
  // The fill writes one word per cycle and hands over to RUN on the last
  // address. busy_q is registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= InitZero ? INIT : RUN;
      busy_q     <= InitZero;
      init_cnt_q <= '0;
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == LastAddr) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // After a grant, move the priority pointer one past the winner.
  // With no grant, the pointer holds its position.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (grant_valid) begin
      rr_q <= (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
    end
  end

  // Response pipeline: each grant's index rides alongside the SRAM access.
  // It emerges exactly Latency cycles later. Reset flushes it, so accesses
  // granted before a reset never report back.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid_q <= '0;
      pipe_idx_q   <= '0;
    end else begin
      pipe_valid_q[0] <= grant_valid;
      pipe_idx_q[0]   <= grant_idx;
      for (int s = 1; s < Latency; s++) begin
        pipe_valid_q[s] <= pipe_valid_q[s-1];
        pipe_idx_q[s]   <= pipe_idx_q[s-1];
      end
    end
  end

  // Decode the pipeline output into the per-requester response strobe.
  always_comb begin
    rvalid_o = '0;
    if (!rst_i && pipe_valid_q[Latency-1]) begin
      rvalid_o[pipe_idx_q[Latency-1]] = 1'b1;
    end
  end

  assign rdata_o = sram_rdata_i;
  assign busy_o  = rst_i ? InitZero : busy_q;

endmodule
